fir_filter_cfg: RTL and testbench
=================================

FIR_FILTER_CFG -- requirements
Module: fir_filter_cfg

Interface
REQ-001 Parameter DATA_W, default 8, sample width (signed two's complement).
REQ-002 Parameter COEF_W, default 8, coefficient width (signed two's complement).
REQ-003 Parameter TAPS, default 8, number of taps (2..64).
REQ-004 Parameter OUT_W, default 16, output width (signed), at most DATA_W+COEF_W+clog2(TAPS).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  x_in carries a sample this cycle.
REQ-008 x_in  input  DATA_W  input sample.
REQ-009 flush  input  1  synchronous clear of the delay line and pipeline.
REQ-010 coef_wr  input  1  coefficient write strobe.
REQ-011 coef_addr  input  clog2(TAPS)  tap index to write.
REQ-012 coef_data  input  COEF_W  coefficient value.
REQ-013 out_valid  output  1  y_out holds a new result this cycle (one-cycle pulse per result).
REQ-014 y_out  output  OUT_W  filter result.
REQ-015 sat  output  1  y_out was saturated; qualified by out_valid.

Function
REQ-016 Delay line d[0..TAPS-1] SHALL shift only on a rising edge with in_valid=1: d[0]<=x_in, d[i]<=d[i-1].
REQ-017 Result SHALL be y = sum over i of c[i]*d[i], d[0] the newest sample, computed at full width DATA_W+COEF_W+clog2(TAPS) with no intermediate truncation.
REQ-018 Pipeline: edge k accepts the sample; edge k+1 registers the TAPS products; edge k+2 registers y_out, sat and out_valid=1.
REQ-019 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid; throughput one sample per cycle; no backpressure.
REQ-020 out_valid SHALL be 0 in any cycle whose corresponding edge k had in_valid=0; y_out and sat SHALL hold their previous values when out_valid=0.
REQ-021 Full-width sum above 2^(OUT_W-1)-1 SHALL give y_out=2^(OUT_W-1)-1 and sat=1; below -2^(OUT_W-1) SHALL give y_out=-2^(OUT_W-1) and sat=1; otherwise y_out=sum and sat=0.
REQ-022 coef_wr=1 at edge j SHALL set c[coef_addr]<=coef_data; products registered at edges after j use the new value, and products registered at edge j use the old value.
REQ-023 coef_wr with coef_addr >= TAPS SHALL be ignored.
REQ-024 coef_wr and in_valid in the same cycle SHALL both take effect; neither blocks the other.
REQ-025 flush=1 at an edge SHALL zero d[], clear both pipeline valid bits (no out_valid for in-flight samples) and leave coefficients, y_out and sat unchanged; flush takes priority over in_valid at that edge.

Reset
REQ-026 reset=1 SHALL immediately, without a clock edge, set d[]=0, all pipeline registers=0, out_valid=0, y_out=0 and sat=0.
REQ-027 reset SHALL set every coefficient c[i]=1, giving a TAPS-point moving sum.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; the first out_valid after release SHALL correspond to the first sample accepted after release.

Verification
REQ-029 Defaults, reset then x_in=1,2,3,4,5 on consecutive cycles with in_valid=1, then x_in=0 for 8 cycles -> y_out sequence 1,3,6,10,15,15,15,15,14,12,9,5,0; each value appears 2 cycles after its sample; sat=0.
REQ-030 All coefficients written to 127, then x_in=127 for 8 cycles -> final y_out=32767, sat=1; with x_in=-128 for 8 cycles -> y_out=-32768, sat=1.
REQ-031 in_valid toggled 1,0,1,0 with x_in=4 -> out_valid follows the same pattern delayed by 2 cycles; y_out=4 then 8; y_out holds when out_valid=0.
REQ-032 coef_wr at addr 0 with data 3, in the same cycle as in_valid with x_in=2 (other coefficients 0, d[] previously 0) -> y_out=6, because the product is registered after the write edge; a write to addr TAPS leaves all outputs unchanged.
REQ-033 flush asserted one cycle after two accepted samples -> no out_valid for either sample; next sample x_in=5 -> y_out=5.
REQ-034 reset asserted asynchronously between edges during streaming -> outputs and out_valid go to 0 at once; after release, coefficients read back as moving sum (x_in=2 -> y_out=2).

Source files
------------

// File: rtl/fir_filter_cfg.sv
// Purpose : runtime-programmable signed FIR filter with output saturation.
// Latency : 2 cycles from the accepting edge to out_valid; one sample per cycle.
// Backpressure: none; every accepted sample produces one result unless flushed or reset.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-high reset (coefficients return to 1)
//   in_valid   x_in carries a sample this cycle
//   x_in       signed input sample
//   flush      synchronous clear of delay line and in-flight results
//   coef_wr    coefficient write strobe
//   coef_addr  tap index for the write (out-of-range indices are dropped)
//   coef_data  signed coefficient value
//   out_valid  one-cycle pulse per result
//   y_out      saturated signed result, held between pulses
//   sat        y_out was clipped, qualified by out_valid

module fir_filter_cfg #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        x_in,
  input  logic                     flush,
  input  logic                     coef_wr,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         y_out,
  output logic                     sat
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;   // exact product width
  localparam int FW = PW + AW;           // exact sum width, no truncation anywhere

  // Saturation bounds expressed at full sum width so the compare is exact.
  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_d    [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic signed [PW-1:0]     r_prod [TAPS];
  logic                     r_v1;
  logic                     r_v2;

  logic                     w_addr_ok;
  logic signed [FW-1:0]     w_sum;
  logic [OUT_W-1:0]         w_y;
  logic                     w_sat;

  // When TAPS is a power of two every encodable address is a real tap, so
  // the range check collapses to a constant.
  generate
    if (TAPS == (1 << AW)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = (int'(coef_addr) < TAPS);
    end
  endgenerate

  // Stage 0: coefficient file and delay line. A coefficient written here is
  // seen by the product registered on the following edge, so a write and a
  // sample on the same edge combine with the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_d[i]    <= '0;
        r_coef[i] <= COEF_W'(1);
      end
      r_v1 <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_wr && w_addr_ok && (coef_addr == AW'(i))) begin
          r_coef[i] <= coef_data;
        end
      end
      if (flush) begin
        // flush wins over a sample presented on the same edge
        for (int i = 0; i < TAPS; i++) begin
          r_d[i] <= '0;
        end
        r_v1 <= 1'b0;
      end else begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_d[0] <= x_in;
          for (int i = 1; i < TAPS; i++) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
    end
  end

  // Stage 1: per-tap products. Operands are sign-extended to the product
  // width first so the multiply is exact without relying on context sizing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_prod[i] <= '0;
      end
      r_v2 <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        r_prod[i] <= PW'(r_coef[i]) * PW'(r_d[i]);
      end
      r_v2 <= r_v1 & ~flush;
    end
  end

  // Adder tree and saturation at full width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + FW'(r_prod[i]);
    end
    w_y   = w_sum[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_sum > SAT_MAX) begin
      w_y   = SAT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_sum < SAT_MIN) begin
      w_y   = SAT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  // Stage 2: output register. A flush on this edge also suppresses the
  // oldest in-flight result, and y_out/sat only move with a real result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= r_v2 & ~flush;
      if (r_v2 && !flush) begin
        y_out <= w_y;
        sat   <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_cfg.sv
module tb_fir_filter_cfg;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 16;
  localparam int AW     = $clog2(TAPS);
  localparam longint SMAX = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (OUT_W-1));

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] x_in = '0;
  logic              flush = 1'b0;
  logic              coef_wr = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              out_valid;
  logic [OUT_W-1:0]  y_out;
  logic              sat;

  fir_filter_cfg #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .y_out(y_out), .sat(sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: sample history, coefficient array and a queue of
  // results tagged with the edge on which they must appear.
  typedef struct { int due; int y; bit s; } res_t;
  int   m_hist [TAPS];
  int   m_coef [TAPS];
  res_t m_q[$];
  int   edge_no = 0;
  bit   exp_vld = 1'b0;
  int   exp_y   = 0;
  bit   exp_sat = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 1;
    end
    m_q.delete();
    exp_vld = 1'b0;
    exp_y   = 0;
    exp_sat = 1'b0;
  endtask

  task automatic drive(input logic iv, input int x, input logic fl,
                       input logic cw, input int ca, input int cd);
    in_valid  = iv;
    x_in      = x[DATA_W-1:0];
    flush     = fl;
    coef_wr   = cw;
    coef_addr = ca[AW-1:0];
    coef_data = cd[COEF_W-1:0];
  endtask

  // Advance one edge in both DUT and model; outputs are sampled 1 time unit later.
  task automatic step();
    longint acc;
    res_t   r;
    @(posedge clk);
    edge_no++;
    if (coef_wr) m_coef[int'(coef_addr)] = int'($signed(coef_data));
    if (flush) begin
      for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
      m_q.delete();
    end else if (in_valid) begin
      for (int i = TAPS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'($signed(x_in));
      acc = 0;
      for (int i = 0; i < TAPS; i++) acc += longint'(m_coef[i]) * longint'(m_hist[i]);
      r.due = edge_no + 2;
      if (acc > SMAX) begin r.y = int'(SMAX); r.s = 1'b1; end
      else if (acc < SMIN) begin r.y = int'(SMIN); r.s = 1'b1; end
      else begin r.y = int'(acc); r.s = 1'b0; end
      m_q.push_back(r);
    end
    exp_vld = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == edge_no) begin
      r = m_q.pop_front();
      exp_vld = 1'b1;
      exp_y   = r.y;
      exp_sat = r.s;
    end
    #1;
  endtask

  task automatic set_all_coefs(input int v);
    for (int i = 0; i < TAPS; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1, i, v);
      step();
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (y_out !== '0) begin bad++; $display("FAIL reset_y_out got=%0d want=0", $signed(y_out)); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b want=0", sat); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_moving_sum();
    int seq [13] = '{1, 3, 6, 10, 15, 15, 15, 15, 14, 12, 9, 5, 0};
    int got [16];
    int n = 0;
    for (int c = 0; c < 15; c++) begin
      if (c < 5) drive(1'b1, c + 1, 1'b0, 1'b0, 0, 0);
      else if (c < 13) drive(1'b1, 0, 1'b0, 1'b0, 0, 0);
      else drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL ramp_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
      total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL ramp_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
      total++; if (sat !== exp_sat) begin bad++; $display("FAIL ramp_sat edge=%0d got=%0b want=%0b", edge_no, sat, exp_sat); end
      if (out_valid === 1'b1 && n < 16) begin got[n] = int'($signed(y_out)); n++; end
    end
    total++; if (n !== 13) begin bad++; $display("FAIL ramp_count got=%0d want=13", n); end
    for (int i = 0; i < 13 && i < n; i++) begin
      total++; if (got[i] !== seq[i]) begin bad++; $display("FAIL ramp_seq idx=%0d got=%0d want=%0d", i, got[i], seq[i]); end
    end
  endtask

  task automatic test_saturation();
    set_all_coefs(127);
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 10; c++) begin
        if (c < 8) drive(1'b1, (pass == 0) ? 127 : -128, 1'b0, 1'b0, 0, 0);
        else drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        step();
        total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL sat_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
        total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL sat_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
        total++; if (sat !== exp_sat) begin bad++; $display("FAIL sat_flag edge=%0d got=%0b want=%0b", edge_no, sat, exp_sat); end
      end
      total++; if (int'($signed(y_out)) !== ((pass == 0) ? 32767 : -32768)) begin
        bad++; $display("FAIL sat_final pass=%0d got=%0d want=%0d", pass, $signed(y_out), (pass == 0) ? 32767 : -32768);
      end
      total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_final_flag pass=%0d got=%0b want=1", pass, sat); end
    end
  endtask

  task automatic test_gaps();
    int got [4];
    int n = 0;
    set_all_coefs(1);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
    step();
    for (int c = 0; c < 6; c++) begin
      drive((c < 4) ? ~c[0] : 1'b0, 4, 1'b0, 1'b0, 0, 0);
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL gap_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
      total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL gap_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
      if (out_valid === 1'b1 && n < 4) begin got[n] = int'($signed(y_out)); n++; end
    end
    total++; if (n !== 2) begin bad++; $display("FAIL gap_count got=%0d want=2", n); end
    if (n >= 2) begin
      total++; if (got[0] !== 4 || got[1] !== 8) begin bad++; $display("FAIL gap_values got=%0d,%0d want=4,8", got[0], got[1]); end
    end
  endtask

  task automatic test_coef_same_cycle();
    for (int i = 1; i < TAPS; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1, i, 0);
      step();
    end
    drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
    step();
    drive(1'b1, 2, 1'b0, 1'b1, 0, 3);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL wr_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
      total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL wr_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
    end
    total++; if (int'($signed(y_out)) !== 6) begin bad++; $display("FAIL wr_same_cycle got=%0d want=6", $signed(y_out)); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    set_all_coefs(1);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 7, 1'b0, 1'b0, 0, 0);
        1: drive(1'b1, 9, 1'b0, 1'b0, 0, 0);
        2: drive(1'b1, 11, 1'b1, 1'b0, 0, 0);
        default: drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
      endcase
      step();
      if (c >= 2 && out_valid === 1'b1) pulses++;
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL flush_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_no_output got=%0d want=0", pulses); end
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 5, 1'b0, 1'b0, 0, 0);
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL flush_after_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
    end
    total++; if (int'($signed(y_out)) !== 5) begin bad++; $display("FAIL flush_after_y got=%0d want=5", $signed(y_out)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, int'($urandom % 256), ($urandom % 32) == 0,
            ($urandom % 8) == 0, int'($urandom % TAPS), int'($urandom % 256));
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL rnd_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
      total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL rnd_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
      total++; if (sat !== exp_sat) begin bad++; $display("FAIL rnd_sat edge=%0d got=%0b want=%0b", edge_no, sat, exp_sat); end
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_async_reset();
    set_all_coefs(1);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 3, 1'b0, 1'b0, 0, 0);
      step();
    end
    total++; if (out_valid !== 1'b1 || int'($signed(y_out)) !== exp_y) begin
      bad++; $display("FAIL arst_pre got_vld=%0b got_y=%0d want_vld=1 want_y=%0d", out_valid, $signed(y_out), exp_y);
    end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_vld got=%0b want=0", out_valid); end
    total++; if (y_out !== '0) begin bad++; $display("FAIL arst_y got=%0d want=0", $signed(y_out)); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL arst_sat got=%0b want=0", sat); end
    drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 2, 1'b0, 1'b0, 0, 0);
      step();
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL arst_after_vld edge=%0d got=%0b want=%0b", edge_no, out_valid, exp_vld); end
      total++; if (int'($signed(y_out)) !== exp_y) begin bad++; $display("FAIL arst_after_y edge=%0d got=%0d want=%0d", edge_no, $signed(y_out), exp_y); end
    end
    total++; if (int'($signed(y_out)) !== 2) begin bad++; $display("FAIL arst_moving_sum got=%0d want=2", $signed(y_out)); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_moving_sum();
    test_saturation();
    test_gaps();
    test_coef_same_cycle();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
